// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity, framing and overrun reporting.
// Words are held behind a valid/read handshake; errored frames are still delivered.
module uart_rx_param #(
    parameter int OVERSAMPLE = 20,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
    localparam bit PEN = PARITY_EN != 0;
    localparam bit PODD = PARITY_ODD != 0;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sync, rx_s, rx_prev, par_bit, ferr, tick;

    assign tick = cnt == LAST;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            par_bit <= 1'b0;
            ferr <= 1'b0;
            {sync, rx_s, rx_prev} <= 3'b111;
            data <= '0;
            valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            {sync, rx_s, rx_prev} <= {rx, sync, rx_s};
            cnt <= cnt + CW'(1);
            if (valid && read) begin
                valid <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                IDLE: if (!rx_s && rx_prev) begin
                    state <= START;
                    cnt <= '0;
                end
                // a start bit that is high again at mid-bit was a glitch
                START: if (cnt == HALF) begin
                    cnt <= '0;
                    idx <= '0;
                    ferr <= 1'b0;
                    state <= rx_s ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    cnt <= '0;
                    shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                    idx <= (idx == DLAST) ? 4'd0 : idx + 4'd1;
                    if (idx == DLAST) state <= PEN ? PARITY : STOP;
                end
                PARITY: if (tick) begin
                    cnt <= '0;
                    par_bit <= rx_s;
                    state <= STOP;
                end
                STOP: if (tick) begin
                    cnt <= '0;
                    idx <= idx + 4'd1;
                    ferr <= ferr | !rx_s;
                    if (idx == SLAST) begin
                        state <= IDLE;
                        data <= shreg;
                        parity_err <= PEN & ((^shreg) ^ par_bit ^ PODD);
                        frame_err <= ferr | !rx_s;
                        valid <= 1'b1;
                        if (valid && !read) overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames checked every cycle against a
// time-indexed frame model, plus literal expectations for the key scenarios.
module tb_uart_rx_param;
    localparam int OS = 20, DB = 8, PE = 1, SB = 1, H = OS / 2;
    localparam int NB = DB + PE + SB;
    localparam bit PODD = 1'b0;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, read = 1'b0;
    logic [DB-1:0] data;
    logic valid, parity_err, frame_err, overrun, busy;
    logic rx2 = 1'b1, read2 = 1'b0;
    logic [6:0] data2;
    logic valid2, parity_err2, frame_err2, overrun2, busy2;

    uart_rx_param dut (.clk(clk), .rst(rst), .rx(rx), .read(read), .data(data), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy));

    uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .read(read2), .data(data2), .valid(valid2),
        .parity_err(parity_err2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, lr = 0, s0 = 0, e = 0, e0 = 0;
    int rise_edge = -1, rise2_edge = -1, rises = 0, busy_cnt = 0;
    bit busy_at_rise, valid_q, valid2_q, chk = 1'b1;
    bit r_h [65536];
    bit act, commit, pv, pb, fe, m_valid, m_pe, m_fe, m_ov;
    logic [DB-1:0] m_data, word;

    // line level seen by the synchroniser output / delayed flop after edge n
    function automatic bit rxs_after(int n);
        return (n - lr <= 1) ? 1'b1 : r_h[n-1];
    endfunction
    function automatic bit prev_after(int n);
        return (n - lr <= 2) ? 1'b1 : r_h[n-2];
    endfunction

    always @(posedge clk) begin
        e = cyc;
        pv = m_valid;
        commit = 1'b0;
        r_h[e] = rx;
        if (rst) begin
            lr = e;
            act = 1'b0;
            m_data = '0;
            {m_valid, m_pe, m_fe, m_ov} = 4'b0;
        end else begin
            if (!act) begin
                if (!rxs_after(e - 1) && prev_after(e - 1)) begin
                    act = 1'b1;
                    s0 = e;
                end
            end else if (e - s0 == H && rxs_after(e - 1)) act = 1'b0;
            else if (e - s0 == H + NB * OS) begin
                act = 1'b0;
                commit = 1'b1;
            end
            if (pv && read) begin
                m_valid = 1'b0;
                m_ov = 1'b0;
            end
            if (commit) begin
                for (int k = 0; k < DB; k++) word[k] = rxs_after(s0 + H + (k + 1) * OS - 1);
                pb = rxs_after(s0 + H + (DB + 1) * OS - 1);
                fe = 1'b0;
                for (int j = 0; j < SB; j++) if (!rxs_after(s0 + H + (DB + PE + 1 + j) * OS - 1)) fe = 1'b1;
                if (pv && !read) m_ov = 1'b1;
                m_valid = 1'b1;
                m_data = word;
                m_pe = (PE != 0) && ((^word) ^ pb ^ PODD);
                m_fe = fe;
            end
        end
        cyc = e + 1;
    end

    always @(negedge clk) if (chk) begin
        total++;
        if ({data, valid, parity_err, frame_err, overrun, busy} !== {m_data, m_valid, m_pe, m_fe, m_ov, act}) begin
            bad++;
            $display("FAIL model cyc=%0d got d=%h v=%b pe=%b fe=%b ov=%b busy=%b exp d=%h v=%b pe=%b fe=%b ov=%b busy=%b",
                cyc, data, valid, parity_err, frame_err, overrun, busy, m_data, m_valid, m_pe, m_fe, m_ov, act);
        end
    end

    always @(posedge clk) begin
        #1;
        if (valid && !valid_q) begin
            rise_edge = cyc - 1;
            busy_at_rise = busy;
            rises++;
        end
        if (valid2 && !valid2_q) rise2_edge = cyc - 1;
        if (busy) busy_cnt++;
        valid_q = valid;
        valid2_q = valid2;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n, input bit rnd_rd);
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            read = rnd_rd && ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        read = 1'b0;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit stop_v,
                              input bit rd_commit, input bit rnd_rd, output int start);
        logic [NB:0] bits;
        bits = {{SB{stop_v}}, (^d) ^ PODD ^ bad_par, d, 1'b0};
        start = cyc;
        for (int i = 0; i < (NB + 1) * OS; i++) begin
            rx = bits[i/OS];
            read = rd_commit ? (cyc == start + 2 + H + NB * OS) : (rnd_rd && ($urandom_range(0, 15) == 0));
            @(negedge clk);
        end
        read = 1'b0;
    endtask

    initial begin
        logic [9:0] bits2;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(10, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, e0);
        check("t1_latency", rise_edge - e0, 212);
        check("t1_busy_at_valid", busy_at_rise, 0);
        check("t1_data", data, 'h55);
        check("t1_model_data", m_data, 'h55);
        check("t1_perr", parity_err, 0);
        check("t1_ferr", frame_err, 0);
        pulse_read();
        check("t1_read_valid", valid, 0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, e0);
        check("t2_data", data, 'h55);
        check("t2_perr", parity_err, 1);
        check("t2_ferr", frame_err, 0);
        pulse_read();
        check("t2_read_valid", valid, 0);
        rises = 0;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, e0);
        repeat (300) @(negedge clk);
        check("t3_rises", rises, 1);
        check("t3_data", data, 'hA3);
        check("t3_ferr", frame_err, 1);
        check("t3_model_ferr", m_fe, 1);
        check("t3_busy", busy, 0);
        idle(5, 1'b0);
        pulse_read();
        idle(30, 1'b0);
        busy_cnt = 0;
        rises = 0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(40, 1'b0);
        check("t4_busy_cycles", busy_cnt, 10);
        check("t4_rises", rises, 0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, e0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, e0);
        check("t5_data", data, 'h22);
        check("t5_valid", valid, 1);
        check("t5_overrun", overrun, 1);
        pulse_read();
        check("t5_read_valid", valid, 0);
        check("t5_read_overrun", overrun, 0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, e0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, e0);
        check("t5b_data", data, 'h22);
        check("t5b_valid", valid, 1);
        check("t5b_overrun", overrun, 0);
        pulse_read();
        idle(20, 1'b0);
        rx = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(300, 1'b0);
        check("t6_valid", valid, 0);
        check("t6_busy", busy, 0);
        check("t6_data", data, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, e0);
        check("t6_data_after", data, 'h3C);
        check("t6_valid_after", valid, 1);
        pulse_read();
        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, 1'b0, 1'b1, e0);
            idle($urandom_range(0, 30), 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 15)) @(negedge clk);
                idle(15, 1'b1);
            end
        end
        idle(260, 1'b1);
        pulse_read();
        bits2 = {2'b11, 7'h5A, 1'b0};
        e0 = cyc;
        for (int i = 0; i < 160; i++) begin
            rx2 = bits2[i/16];
            @(negedge clk);
        end
        rx2 = 1'b1;
        check("b2_latency", rise2_edge - e0, 154);
        check("b2_data", data2, 'h5A);
        check("b2_valid", valid2, 1);
        check("b2_perr", parity_err2, 0);
        check("b2_ferr", frame_err2, 0);
        check("b2_overrun", overrun2, 0);
        check("b2_busy", busy2, 0);
        idle(5, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised oversampling UART receiver: the next generation of the team's fixed 9-bit serial receiver. It synchronises the asynchronous `rx` line, validates the start bit at mid-bit, and samples a configurable number of data bits, an optional parity bit and one or two stop bits. It presents each received word behind a valid/read handshake, with parity-error, framing-error and overrun flags. It sits between the board RX pin and the host-side register or FIFO logic.

## Interface
- OVERSAMPLE, 20: clk cycles per bit; must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame (5..9), LSB first.
- PARITY_EN, 1: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits checked (1 or 2).
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- rx  in  1  asynchronous serial line, idle high.
- read  in  1  consumer acknowledge; pops the held word.
- data  out  DATA_BITS  last committed word.
- valid  out  1  word available in `data`.
- parity_err  out  1  parity mismatch for the word in `data`.
- frame_err  out  1  a stop bit was sampled low for the word in `data`.
- overrun  out  1  a word was overwritten before it was read (sticky until read).
- busy  out  1  FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser to give rx_s; a third flop gives rx_prev. All three reset to 1.
- Falling edge = rx_s==0 && rx_prev==1.
- The bit-timing counter cnt is $clog2(OVERSAMPLE) bits wide. It clears on every state transition and on every sample; otherwise it increments.
- H = OVERSAMPLE/2.
- FSM states and transitions:
  - IDLE: on a falling edge, go to START with cnt=0.
  - START: at cnt==H-1, sample rx_s. If 0, go to DATA. If 1, it is a false start: go to IDLE with no flags and no commit.
  - DATA: at cnt==OVERSAMPLE-1, shift rx_s into the MSB of a DATA_BITS shift register (LSB-first reception). After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: at cnt==OVERSAMPLE-1, sample into par_bit, then go to STOP.
  - STOP: at cnt==OVERSAMPLE-1, sample. Any low sample sets an internal ferr. After STOP_BITS samples, commit and go to IDLE.
- Commit (registered at the edge of the last stop sample):
  - data <= shreg.
  - parity_err <= PARITY_EN && (^shreg ^ par_bit ^ PARITY_ODD).
  - frame_err <= ferr.
  - valid <= 1.
- A frame with errors is still committed. The receiver only re-arms on a fresh falling edge, so a line held low after a frame error is not re-received.
- Handshake: valid && read on a clock edge gives valid=0 and overrun=0 on the next cycle. data and the error flags hold their value until the next commit.
- Overrun: a commit while valid==1 and read==0 sets overrun=1 and overwrites data and the error flags.
- Commit and read in the same cycle: the new word loads, valid stays 1, and overrun is not set.
- read while valid==0 is ignored.
- busy = (state != IDLE).
- rst at any point, including mid-frame, forces:
  - state IDLE, cnt=0, shreg=0;
  - data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0;
  - synchroniser flops to 1.
  - No partial word is committed.

## Timing
- Let E0 be the first clk edge at which rx is low.
- The FSM enters START at E0+2. The start bit is sampled at E0+2+H.
- Data bit k (0-based) is sampled at E0+2+H+(k+1)·OVERSAMPLE.
- valid rises at E0+2+H+(DATA_BITS+PARITY_EN+STOP_BITS)·OVERSAMPLE. With the defaults this is E0+212.
- A new falling edge is accepted from the first cycle back in IDLE, so back-to-back frames with no idle time are supported.
- valid, flags and data are registered outputs with no combinational paths from inputs.
- read→valid low latency: 1 cycle.

## Test plan
- Defaults, frame 0x55 with even parity bit 0 and stop 1, each bit 20 clk -> data=0x55, valid=1 at E0+212, parity_err=0, frame_err=0, busy low at the same edge.
- Same frame with parity bit 1 -> data=0x55, parity_err=1, frame_err=0; read pulse -> valid=0 next cycle.
- Frame 0xA3 with stop bit driven 0 -> valid=1, data=0xA3, frame_err=1. With rx held low afterwards, no second valid until rx returns high and falls again.
- rx low pulse of 5 clk, then high -> busy=1 for 10 cycles then 0, valid never asserted.
- Two back-to-back frames 0x11 then 0x22 with read held 0 -> data=0x22, valid=1, overrun=1. Single read -> valid=0, overrun=0. Repeat with read pulsed on the second commit edge -> overrun=0.
- rst asserted mid-DATA, then a clean 0x3C frame; and a separate build with DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, OVERSAMPLE=16 receiving 0x5A -> no stale commit after reset, data=0x3C. For the second build: data=0x5A, valid at E0+2+8+9·16=E0+154.
